// File: rtl/jk_pkg.sv
// Shared types and defaults for the JK flip-flop command sequencer.
package jk_pkg;

  localparam int JK_DEPTH_DEF = 4;
  localparam int JK_CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } jk_state_e;

  // Next Q of a JK flip-flop given the current Q and the J/K it sees.
  function automatic logic jk_next_q(input logic q, input logic j, input logic k);
    logic w_next;
    w_next = q;
    case ({j, k})
      2'b00:   w_next = q;
      2'b01:   w_next = 1'b0;
      2'b10:   w_next = 1'b1;
      default: w_next = ~q;
    endcase
    return w_next;
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Small synchronous command FIFO; pointers carry an extra wrap bit so that
// full and empty are distinguished without a separate occupancy counter.
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [DW-1:0] r_mem [DEPTH];
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_empty   = (r_wptr == r_rptr);
  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign o_data    = r_mem[r_rptr[AW-1:0]];

  // Pointer update: flush discards everything and wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Command sequencer feeding a JK flip-flop: queues {op,count} commands and
// drives registered J/K one cycle per repetition, tracking predicted Q.
// Optional Q feedback checker is compiled in with JK_SEQ_QCHECK_EN.
module jk_cmd_sequencer
  import jk_pkg::*;
#(
  parameter int DEPTH = JK_DEPTH_DEF,
  parameter int CNT_W = JK_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             J,
  output logic             K,
  output logic             busy,
  output logic             q_model
`ifdef JK_SEQ_QCHECK_EN
  ,
  input  logic             q_fb,
  output logic             q_err
`endif
);

  localparam int DW = 2 + CNT_W;

  jk_state_e        r_state;
  logic [CNT_W-1:0] r_rem;
  logic             r_j;
  logic             r_k;
  logic             r_q;
  logic [DW-1:0]    w_head;
  jk_op_e           w_head_op;
  logic [CNT_W-1:0] w_head_cnt;
  logic [CNT_W-1:0] w_head_rem;
  logic             w_full;
  logic             w_empty;
  logic             w_last;
  logic             w_pop;

  jk_cmd_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_push  (cmd_valid),
    .i_data  ({cmd_op, cmd_count}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head_op  = jk_op_e'(w_head[DW-1:CNT_W]);
  assign w_head_cnt = w_head[CNT_W-1:0];
  assign w_head_rem = (w_head_cnt == '0) ? CNT_W'(1) : w_head_cnt;
  assign w_last     = (r_rem == CNT_W'(1));
  assign w_pop      = !flush && !w_empty &&
                      ((r_state == ST_IDLE) || ((r_state == ST_ISSUE) && w_last));

  assign cmd_ready = !w_full;
  assign busy      = (r_state == ST_ISSUE) || !w_empty;
  assign J         = r_j;
  assign K         = r_k;
  assign q_model   = r_q;

  // Issue FSM: loads the head command, holds J/K for its count, chains the next without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_rem   <= '0;
      r_j     <= 1'b0;
      r_k     <= 1'b0;
    end else if (flush) begin
      r_state <= ST_IDLE;
      r_rem   <= '0;
      r_j     <= 1'b0;
      r_k     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_state <= ST_ISSUE;
            r_rem   <= w_head_rem;
            r_j     <= w_head_op[1];
            r_k     <= w_head_op[0];
          end
        end
        ST_ISSUE: begin
          if (w_last) begin
            if (!w_empty) begin
              r_rem <= w_head_rem;
              r_j   <= w_head_op[1];
              r_k   <= w_head_op[0];
            end else begin
              r_state <= ST_IDLE;
              r_rem   <= '0;
              r_j     <= 1'b0;
              r_k     <= 1'b0;
            end
          end else begin
            r_rem <= r_rem - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_rem   <= '0;
          r_j     <= 1'b0;
          r_k     <= 1'b0;
        end
      endcase
    end
  end

  // Q model follows the J/K currently driven; flush does not freeze it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= 1'b0;
    else        r_q <= jk_next_q(r_q, r_j, r_k);
  end

`ifdef JK_SEQ_QCHECK_EN
  // Sticky mismatch between flip-flop feedback and the pre-update model value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             q_err <= 1'b0;
    else if (flush)         q_err <= 1'b0;
    else if (q_fb != r_q)   q_err <= 1'b1;
  end
`endif

endmodule

// File: doc/jk_cmd_sequencer.md
# jk_cmd_sequencer

- Upstream command stage for the JK flip-flop: accepts a valid/ready stream of hold/clear/set/toggle commands, each with a repeat count.
- Buffers commands in a small FIFO and drives registered J/K onto the flip-flop one cycle per repetition.
- Keeps a cycle-accurate model of the flip-flop's Q; compiled-in checking of that model against Q feedback is available.

## Interface
- DEPTH, 4: command FIFO entries; power of two, ≥2.
- CNT_W, 4: width of repeat count.
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort: empty FIFO, cancel active command.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept (= !full).
- cmd_op  in  2  00 hold, 01 clear, 10 set, 11 toggle.
- cmd_count  in  CNT_W  repetitions; 0 treated as 1.
- J  out  1  registered J to flip-flop.
- K  out  1  registered K to flip-flop.
- busy  out  1  command active or FIFO non-empty.
- q_model  out  1  predicted flip-flop Q.
- q_fb  in  1  flip-flop Q (only with JK_SEQ_QCHECK_EN).
- q_err  out  1  sticky mismatch flag (only with JK_SEQ_QCHECK_EN).

## Operation
- Reset (rst_n low, async): FIFO empty, FSM IDLE, J=K=0, busy=0, q_model=0, q_err=0, cmd_ready=1 once released.
- Push on posedge when cmd_valid && cmd_ready; entry = {op, count}.
- cmd_ready depends only on FIFO occupancy: a same-cycle pop does not admit a push while full.
- FSM states:
  - IDLE: J=K=0. If FIFO non-empty, pop the head, load op and rem=max(count,1), drive J/K={op}, go ISSUE.
  - ISSUE: J/K held at op, rem decremented each cycle.
    - When rem reaches 1: if FIFO non-empty, pop and load the next command in the same edge with no bubble; else J=K=0, go IDLE.
- Every op, including hold (00), consumes its count cycles; hold therefore acts as a timed gap.
- q_model updates every posedge from current J/K using the flip-flop rule:
  - 00 keep;
  - 01 → 0;
  - 10 → 1;
  - 11 → invert.
- flush (priority over push and pop):
  - next edge FIFO empty, FSM IDLE, J=K=0;
  - any push in that cycle is dropped;
  - q_model still updates from the J/K present in the flush cycle.
- Empty FIFO: no bypass; a command always lands in the FIFO first.
- busy = (state==ISSUE) || !empty.

## Timing
- Push at edge E0 → J/K valid after E1 (if idle) → flip-flop Q changes at E2.
- A command with count N drives J/K for exactly N consecutive cycles.
- Back-to-back commands: no idle cycle between them.
- FIFO pointers are DEPTH-wrapped with an extra wrap bit:
  - full = pointers equal except the MSB;
  - empty = pointers fully equal.
- Reset mid-command: outputs return to reset values immediately (async); queued commands are lost.

## Configuration
- JK_SEQ_QCHECK_EN defined:
  - q_fb and q_err ports exist.
  - Each posedge, q_err sets if q_fb != q_model (model value before that edge's update).
  - q_err is sticky until rst_n or flush.
- JK_SEQ_QCHECK_EN undefined: ports and compare logic absent; all other behaviour identical.

## Structure
- Package jk_pkg:
  - typedef enum jk_op_e {JK_HOLD=2'b00, JK_CLR=2'b01, JK_SET=2'b10, JK_TGL=2'b11};
  - FSM state typedef;
  - default DEPTH/CNT_W constants.
- Sub-module jk_cmd_fifo: synchronous FIFO, parameters DEPTH and data width 2+CNT_W, with push/pop/full/empty/flush.
- Top level contains the FSM, repeat counter, J/K registers, Q model and the optional checker.

## Test plan
- Reset, then push set/count 1 → J=1,K=0 for exactly one cycle, starting 1 cycle after push; q_model 0→1 one edge later; busy then falls.
- Push toggle/count 3 with Q=0 → J=K=1 for 3 cycles; q_model sequence 1,0,1.
- Push DEPTH+1 commands while active with cmd_valid held → cmd_ready low exactly while 4 are queued; no command is lost; J/K show no bubbles between them.
- Push clear/count 0 → treated as one cycle of K=1.
- Flush during the 2nd cycle of a toggle/count 5 with 2 queued → J=K=0 next cycle, busy=0, queued commands never issued.
- With JK_SEQ_QCHECK_EN defined, force q_fb opposite q_model for one cycle → q_err rises and stays 1 until flush; pulse rst_n low mid-command → J=K=0, q_model=0 immediately.
